// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and queued aux results.
// WB passes through with zero latency. A starvation counter forces one WB hold so that queued aux results retire.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_write_enabled,
    input  logic [4:0]  wb_write_address,
    input  logic [3:0]  wb_write_strobe,
    input  logic [31:0] wb_write_data,
    output logic        wb_hold,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_write_address,
    input  logic [3:0]  aux_write_strobe,
    input  logic [31:0] aux_write_data,
    input  logic        aux_flush,
    output logic        rf_write_enabled,
    output logic [4:0]  rf_write_address,
    output logic [3:0]  rf_write_strobe,
    output logic [31:0] rf_write_data,
    output logic        rf_grant_aux,
    output logic [31:0] pending_mask
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FORCE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [4:0]      addr_q [FIFO_DEPTH];
    logic [3:0]      strb_q [FIFO_DEPTH];
    logic [31:0]     data_q [FIFO_DEPTH];

    logic            empty_s;
    logic            full_s;
    logic            force_s;
    logic            push_hs_s;
    logic            push_en_s;
    logic            pop_s;
    logic [AW-1:0]   off_s;
    logic [31:0]     mask_s;

    assign empty_s   = (count_q == CW'(0));
    assign full_s    = (count_q == CW'(FIFO_DEPTH));
    assign force_s   = (state_q == ST_FORCE);
    assign aux_ready = !reset && !full_s && !aux_flush;
    assign push_hs_s = aux_valid && aux_ready;
    // Null writes complete the handshake but never occupy a slot.
    assign push_en_s = push_hs_s && (aux_write_address != 5'd0) && (aux_write_strobe != 4'd0);
    assign pop_s        = !reset && !empty_s && (force_s || !wb_write_enabled);
    assign wb_hold      = !reset && force_s;
    assign rf_grant_aux = pop_s;

    // FIFO pointer, occupancy and starvation counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (aux_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            starve_d = '0;
        end else begin
            if (push_en_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
            else       rd_ptr_d = rd_ptr_q;
            count_d = count_q + CW'(push_en_s) - CW'(pop_s);
            if (pop_s || empty_s)                      starve_d = '0;
            else if (starve_q != SW'(STARVE_LIMIT))    starve_d = starve_q + SW'(1);
            else                                       starve_d = starve_q;
        end
    end

    // State follows the next occupancy and counter, so FORCE lasts one cycle per starved head.
    always_comb begin
        state_d = ST_IDLE;
        if (count_d == CW'(0))                 state_d = ST_IDLE;
        else if (starve_d == SW'(STARVE_LIMIT)) state_d = ST_FORCE;
        else                                   state_d = ST_PENDING;
    end

    // State, pointer and FIFO storage registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                strb_q[i] <= 4'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (push_en_s) begin
                addr_q[wr_ptr_q] <= aux_write_address;
                strb_q[wr_ptr_q] <= aux_write_strobe;
                data_q[wr_ptr_q] <= aux_write_data;
            end
        end
    end

    // Write-port mux: FIFO head when granted, otherwise WB pass-through.
    always_comb begin
        rf_write_enabled = 1'b0;
        rf_write_address = 5'd0;
        rf_write_strobe  = 4'd0;
        rf_write_data    = 32'd0;
        if (pop_s) begin
            rf_write_enabled = 1'b1;
            rf_write_address = addr_q[rd_ptr_q];
            rf_write_strobe  = strb_q[rd_ptr_q];
            rf_write_data    = data_q[rd_ptr_q];
        end else if (!reset && wb_write_enabled) begin
            rf_write_enabled = 1'b1;
            rf_write_address = wb_write_address;
            rf_write_strobe  = wb_write_strobe;
            rf_write_data    = wb_write_data;
        end else begin
            rf_write_enabled = 1'b0;
        end
    end

    // Pending mask from registered FIFO contents only.
    always_comb begin
        mask_s = 32'd0;
        off_s  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off_s = AW'(i) - rd_ptr_q;
            if ({1'b0, off_s} < count_q) mask_s = mask_s | (32'd1 << addr_q[i]);
            else                         mask_s = mask_s;
        end
        pending_mask = reset ? 32'd0 : (mask_s & ~32'd1);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: pass-through, aux drain, starvation hold,
// FIFO full back-pressure, flush, dropped pushes and asynchronous reset.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        wb_write_enabled;
    logic [4:0]  wb_write_address;
    logic [3:0]  wb_write_strobe;
    logic [31:0] wb_write_data;
    logic        wb_hold;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_write_address;
    logic [3:0]  aux_write_strobe;
    logic [31:0] aux_write_data;
    logic        aux_flush;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic        rf_grant_aux;
    logic [31:0] pending_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .wb_write_enabled  (wb_write_enabled),
        .wb_write_address  (wb_write_address),
        .wb_write_strobe   (wb_write_strobe),
        .wb_write_data     (wb_write_data),
        .wb_hold           (wb_hold),
        .aux_valid         (aux_valid),
        .aux_ready         (aux_ready),
        .aux_write_address (aux_write_address),
        .aux_write_strobe  (aux_write_strobe),
        .aux_write_data    (aux_write_data),
        .aux_flush         (aux_flush),
        .rf_write_enabled  (rf_write_enabled),
        .rf_write_address  (rf_write_address),
        .rf_write_strobe   (rf_write_strobe),
        .rf_write_data     (rf_write_data),
        .rf_grant_aux      (rf_grant_aux),
        .pending_mask      (pending_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wb_write_enabled = en;
        wb_write_address = a;
        wb_write_strobe  = s;
        wb_write_data    = d;
    endtask

    task automatic drive_aux(input logic v, input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        aux_valid         = v;
        aux_write_address = a;
        aux_write_strobe  = s;
        aux_write_data    = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        aux_flush = 1'b0;
        drive_wb(1'b0, 5'd0, 4'h0, 32'd0);
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);

        // Outputs forced low while reset is high, even with a WB request present
        @(negedge clock);
        drive_wb(1'b1, 5'd5, 4'hF, 32'h0000_1234);
        #1;
        check_eq("rst_rf_we",     rf_write_enabled, 32'd0);
        check_eq("rst_hold",      wb_hold,          32'd0);
        check_eq("rst_aux_ready", aux_ready,        32'd0);
        check_eq("rst_grant",     rf_grant_aux,     32'd0);
        check_eq("rst_pending",   pending_mask,     32'd0);

        // 1: WB pass-through, zero latency
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("t1_rf_we",   rf_write_enabled, 32'd1);
        check_eq("t1_addr",    rf_write_address, 32'd5);
        check_eq("t1_strb",    rf_write_strobe,  32'hF);
        check_eq("t1_data",    rf_write_data,    32'h0000_1234);
        check_eq("t1_hold",    wb_hold,          32'd0);
        check_eq("t1_grant",   rf_grant_aux,     32'd0);
        check_eq("t1_aready",  aux_ready,        32'd1);

        // 2: aux push, written the next idle cycle
        @(negedge clock);
        drive_wb(1'b0, 5'd0, 4'h0, 32'd0);
        drive_aux(1'b1, 5'd8, 4'hF, 32'h0000_AAAA);
        #1;
        check_eq("t2_push_ready", aux_ready,        32'd1);
        check_eq("t2_push_rfwe",  rf_write_enabled, 32'd0);
        check_eq("t2_push_pend",  pending_mask,     32'd0);
        @(negedge clock);
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
        #1;
        check_eq("t2_pend",  pending_mask,     32'h0000_0100);
        check_eq("t2_rf_we", rf_write_enabled, 32'd1);
        check_eq("t2_addr",  rf_write_address, 32'd8);
        check_eq("t2_data",  rf_write_data,    32'h0000_AAAA);
        check_eq("t2_strb",  rf_write_strobe,  32'hF);
        check_eq("t2_grant", rf_grant_aux,     32'd1);
        @(negedge clock);
        #1;
        check_eq("t2_pend_clr", pending_mask,     32'd0);
        check_eq("t2_idle",     rf_write_enabled, 32'd0);

        // Dropped pushes: address 0 and strobe 0
        @(negedge clock);
        drive_aux(1'b1, 5'd0, 4'hF, 32'h0000_0005);
        #1;
        check_eq("drop_a0_ready", aux_ready, 32'd1);
        @(negedge clock);
        drive_aux(1'b1, 5'd9, 4'h0, 32'h0000_0006);
        #1;
        check_eq("drop_s0_ready", aux_ready,        32'd1);
        check_eq("drop_a0_pend",  pending_mask,     32'd0);
        check_eq("drop_a0_rfwe",  rf_write_enabled, 32'd0);
        @(negedge clock);
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
        #1;
        check_eq("drop_s0_pend", pending_mask,     32'd0);
        check_eq("drop_s0_rfwe", rf_write_enabled, 32'd0);

        // 3: starvation under continuous WB
        @(negedge clock);
        drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_1000);
        drive_aux(1'b1, 5'd3, 4'h3, 32'h0000_0033);
        #1;
        check_eq("t3_push_data",  rf_write_data, 32'h0000_1000);
        check_eq("t3_push_grant", rf_grant_aux,  32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
            drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_1000 + k);
            #1;
            check_eq($sformatf("t3_hold_c%0d", k), wb_hold,       32'd0);
            check_eq($sformatf("t3_data_c%0d", k), rf_write_data, 32'h0000_1000 + k);
            check_eq($sformatf("t3_pend_c%0d", k), pending_mask,  32'h0000_0008);
        end
        @(negedge clock);
        drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_1009);
        #1;
        check_eq("t3_force_hold",  wb_hold,          32'd1);
        check_eq("t3_force_grant", rf_grant_aux,     32'd1);
        check_eq("t3_force_addr",  rf_write_address, 32'd3);
        check_eq("t3_force_data",  rf_write_data,    32'h0000_0033);
        check_eq("t3_force_strb",  rf_write_strobe,  32'h3);
        @(negedge clock);
        #1;
        check_eq("t3_resume_hold", wb_hold,          32'd0);
        check_eq("t3_resume_addr", rf_write_address, 32'd10);
        check_eq("t3_resume_data", rf_write_data,    32'h0000_1009);
        check_eq("t3_resume_pend", pending_mask,     32'd0);

        // 4: fill FIFO under continuous WB, third push stalls until a pop
        @(negedge clock);
        drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_2000);
        drive_aux(1'b1, 5'd1, 4'hF, 32'h0000_0011);
        #1;
        check_eq("t4_push1_ready", aux_ready, 32'd1);
        @(negedge clock);
        drive_aux(1'b1, 5'd2, 4'hF, 32'h0000_0022);
        #1;
        check_eq("t4_push2_ready", aux_ready, 32'd1);
        @(negedge clock);
        drive_aux(1'b1, 5'd4, 4'hF, 32'h0000_0044);
        #1;
        check_eq("t4_full_ready", aux_ready,    32'd0);
        check_eq("t4_full_pend",  pending_mask, 32'h0000_0006);
        for (int k = 3; k <= 8; k++) begin
            @(negedge clock);
            #1;
            check_eq($sformatf("t4_stall_ready_c%0d", k), aux_ready, 32'd0);
            check_eq($sformatf("t4_stall_hold_c%0d", k),  wb_hold,   32'd0);
        end
        @(negedge clock);
        #1;
        check_eq("t4_force_hold",  wb_hold,          32'd1);
        check_eq("t4_force_addr",  rf_write_address, 32'd1);
        check_eq("t4_force_data",  rf_write_data,    32'h0000_0011);
        check_eq("t4_force_ready", aux_ready,        32'd0);
        @(negedge clock);
        #1;
        check_eq("t4_freed_ready", aux_ready,        32'd1);
        check_eq("t4_freed_hold",  wb_hold,          32'd0);
        check_eq("t4_freed_addr",  rf_write_address, 32'd10);
        @(negedge clock);
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
        drive_wb(1'b0, 5'd0, 4'h0, 32'd0);
        #1;
        check_eq("t4_drain1_grant", rf_grant_aux,     32'd1);
        check_eq("t4_drain1_addr",  rf_write_address, 32'd2);
        check_eq("t4_drain1_data",  rf_write_data,    32'h0000_0022);
        check_eq("t4_drain1_pend",  pending_mask,     32'h0000_0014);
        @(negedge clock);
        #1;
        check_eq("t4_drain2_addr", rf_write_address, 32'd4);
        check_eq("t4_drain2_data", rf_write_data,    32'h0000_0044);
        check_eq("t4_drain2_pend", pending_mask,     32'h0000_0010);
        @(negedge clock);
        #1;
        check_eq("t4_empty_rfwe", rf_write_enabled, 32'd0);
        check_eq("t4_empty_pend", pending_mask,     32'd0);

        // 5: flush with two entries queued
        @(negedge clock);
        drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_3000);
        drive_aux(1'b1, 5'd6, 4'hF, 32'h0000_0066);
        #1;
        @(negedge clock);
        drive_aux(1'b1, 5'd7, 4'hF, 32'h0000_0077);
        #1;
        @(negedge clock);
        drive_aux(1'b1, 5'd9, 4'hF, 32'h0000_0099);
        aux_flush = 1'b1;
        #1;
        check_eq("t5_flush_ready", aux_ready,    32'd0);
        check_eq("t5_flush_pend",  pending_mask, 32'h0000_00C0);
        check_eq("t5_flush_grant", rf_grant_aux, 32'd0);
        @(negedge clock);
        aux_flush = 1'b0;
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
        drive_wb(1'b0, 5'd0, 4'h0, 32'd0);
        #1;
        check_eq("t5_after_pend",  pending_mask,     32'd0);
        check_eq("t5_after_ready", aux_ready,        32'd1);
        check_eq("t5_after_rfwe",  rf_write_enabled, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            check_eq($sformatf("t5_no_aux_c%0d", k), rf_write_enabled, 32'd0);
        end

        // Flush coinciding with a pop: the pop still writes
        @(negedge clock);
        drive_aux(1'b1, 5'd11, 4'hF, 32'h0000_00BB);
        #1;
        @(negedge clock);
        drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
        aux_flush = 1'b1;
        #1;
        check_eq("t5_fpop_grant", rf_grant_aux,     32'd1);
        check_eq("t5_fpop_addr",  rf_write_address, 32'd11);
        check_eq("t5_fpop_data",  rf_write_data,    32'h0000_00BB);
        @(negedge clock);
        aux_flush = 1'b0;
        #1;
        check_eq("t5_fpop_pend", pending_mask,     32'd0);
        check_eq("t5_fpop_rfwe", rf_write_enabled, 32'd0);

        // 6: asynchronous reset in the middle of FORCE
        @(negedge clock);
        drive_wb(1'b1, 5'd10, 4'hF, 32'h0000_4000);
        drive_aux(1'b1, 5'd12, 4'hF, 32'h0000_00CC);
        #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            drive_aux(1'b0, 5'd0, 4'h0, 32'd0);
            #1;
        end
        @(negedge clock);
        #1;
        check_eq("t6_force_hold", wb_hold, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_rfwe",  rf_write_enabled, 32'd0);
        check_eq("t6_rst_data",  rf_write_data,    32'd0);
        check_eq("t6_rst_hold",  wb_hold,          32'd0);
        check_eq("t6_rst_grant", rf_grant_aux,     32'd0);
        check_eq("t6_rst_pend",  pending_mask,     32'd0);
        check_eq("t6_rst_ready", aux_ready,        32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive_wb(1'b0, 5'd0, 4'h0, 32'd0);
        #1;
        check_eq("t6_post_rfwe",  rf_write_enabled, 32'd0);
        check_eq("t6_post_pend",  pending_mask,     32'd0);
        check_eq("t6_post_hold",  wb_hold,          32'd0);
        check_eq("t6_post_ready", aux_ready,        32'd1);
        @(negedge clock);
        drive_wb(1'b1, 5'd13, 4'h1, 32'h0000_5555);
        #1;
        check_eq("t6_post_wb_addr",  rf_write_address, 32'd13);
        check_eq("t6_post_wb_grant", rf_grant_aux,     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
